// File: rtl/int_controller.sv
`default_nettype none
// ============================================================================
//  Module   : int_controller
//  Purpose  : Memory-mapped interrupt controller in front of the cpu core.
//             Latches rising edges of up to N_SRC interrupt lines as pending,
//             picks the lowest-index unmasked pending source and issues a
//             one-cycle request with a handler vector to the core. Further
//             requests are held off until software writes EOI.
//  Ports    : clock, reset_n          - clock, async active-low reset
//             irq[N_SRC-1:0]          - peripheral interrupt lines
//             addr, w_data, w_en      - core data-memory bus (store side)
//             r_data, hit             - register read data / window hit
//             int_req, int_en, int_vec- request, CTRL, vector to the core
//  Registers: +0 CTRL  +1 MASK  +2 PEND(W1C)  +3 VBASE  +4 CAUSE  +5 EOI
//  Revision : 1.0 - initial release
// ============================================================================
module int_controller #(
   parameter int         N_SRC     = 4,
   parameter logic [7:0] ADDR_BASE = 8'hF0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [N_SRC-1:0] irq,
   input  logic [7:0]       addr,
   input  logic [7:0]       w_data,
   input  logic             w_en,
   output logic [7:0]       r_data,
   output logic             hit,
   output logic             int_req,
   output logic [7:0]       int_en,
   output logic [7:0]       int_vec
);

   localparam logic [7:0] OFF_CTRL  = 8'd0;
   localparam logic [7:0] OFF_MASK  = 8'd1;
   localparam logic [7:0] OFF_PEND  = 8'd2;
   localparam logic [7:0] OFF_VBASE = 8'd3;
   localparam logic [7:0] OFF_CAUSE = 8'd4;
   localparam logic [7:0] OFF_EOI   = 8'd5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [7:0]       ctrl;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] pend;
   logic [7:0]       vbase;
   logic [2:0]       cause;
   logic [N_SRC-1:0] irq_q;

   logic [7:0]       offset;
   logic [7:0]       mask_ext;
   logic [7:0]       pend_ext;
   logic [N_SRC-1:0] cand;
   logic [N_SRC-1:0] irq_edge;
   logic [N_SRC-1:0] w1c_clr;
   logic [N_SRC-1:0] grant_clr;
   logic [N_SRC-1:0] pend_nxt;
   logic [2:0]       win_id;
   logic             any_cand;
   logic             grant;
   logic             wr_ctrl, wr_mask, wr_pend, wr_vbase, wr_eoi;

   // Offset arithmetic wraps mod 256, so the window test is a single compare.
   assign offset = addr - ADDR_BASE;
   assign hit    = (offset < 8'd6);

   assign wr_ctrl  = w_en && (offset == OFF_CTRL);
   assign wr_mask  = w_en && (offset == OFF_MASK);
   assign wr_pend  = w_en && (offset == OFF_PEND);
   assign wr_vbase = w_en && (offset == OFF_VBASE);
   assign wr_eoi   = w_en && (offset == OFF_EOI);

   assign cand     = pend & mask;
   assign irq_edge = irq & ~irq_q;
   assign w1c_clr  = wr_pend ? w_data[N_SRC-1:0] : '0;
   assign grant    = (state == IDLE) && ctrl[0] && any_cand;
   assign int_en   = ctrl;

   // Fixed priority: scanning high to low lets the lowest set index win.
   always_comb begin
      any_cand = 1'b0;
      win_id   = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (cand[i]) begin
            any_cand = 1'b1;
            win_id   = 3'(i);
         end
      end
   end

   // Edge set dominates; W1C and grant auto-clear both simply clear.
   always_comb begin
      grant_clr = '0;
      mask_ext  = 8'h00;
      pend_ext  = 8'h00;
      for (int i = 0; i < N_SRC; i++) begin
         grant_clr[i] = grant && (win_id == 3'(i));
         mask_ext[i]  = mask[i];
         pend_ext[i]  = pend[i];
      end
      pend_nxt = irq_edge | (pend & ~w1c_clr & ~grant_clr);
   end

   always_comb begin
      r_data = 8'h00;
      if (hit) begin
         case (offset)
            OFF_CTRL:  r_data = ctrl;
            OFF_MASK:  r_data = mask_ext;
            OFF_PEND:  r_data = pend_ext;
            OFF_VBASE: r_data = vbase;
            OFF_CAUSE: r_data = {5'b00000, cause};
            default:   r_data = 8'h00;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant)  state_nxt = REQ;
         REQ:                 state_nxt = SERVICE;
         SERVICE: if (wr_eoi) state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         ctrl    <= 8'h00;
         mask    <= '0;
         pend    <= '0;
         vbase   <= 8'h00;
         cause   <= 3'd0;
         irq_q   <= '0;
         int_req <= 1'b0;
         int_vec <= 8'h00;
      end else begin
         state   <= state_nxt;
         irq_q   <= irq;
         pend    <= pend_nxt;
         int_req <= grant;
         if (wr_ctrl)  ctrl  <= w_data;
         if (wr_mask)  mask  <= w_data[N_SRC-1:0];
         if (wr_vbase) vbase <= w_data;
         if (grant) begin
            cause   <= win_id;
            int_vec <= vbase + {3'b000, win_id, 2'b00};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_int_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_controller
//  Purpose  : Directed self-checking bench for int_controller (N_SRC=4,
//             ADDR_BASE=8'hF0). Inputs change 1 time unit after the rising
//             edge; outputs are checked at the same point.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_controller;

   logic       clock;
   logic       reset_n;
   logic [3:0] irq;
   logic [7:0] addr;
   logic [7:0] w_data;
   logic       w_en;
   logic [7:0] r_data;
   logic       hit;
   logic       int_req;
   logic [7:0] int_en;
   logic [7:0] int_vec;

   int checks = 0;
   int errors = 0;

   int_controller #(.N_SRC(4), .ADDR_BASE(8'hF0)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .irq     (irq),
      .addr    (addr),
      .w_data  (w_data),
      .w_en    (w_en),
      .r_data  (r_data),
      .hit     (hit),
      .int_req (int_req),
      .int_en  (int_en),
      .int_vec (int_vec)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [7:0] off, input logic [7:0] d);
      addr   = 8'hF0 + off;
      w_data = d;
      w_en   = 1'b1;
      tick();
      w_en   = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] off, input logic [7:0] expv);
      addr = 8'hF0 + off;
      #1;
      chk(tag, r_data, expv);
   endtask

   initial begin
      reset_n = 1'b0;
      irq     = 4'b0000;
      addr    = 8'h00;
      w_data  = 8'h00;
      w_en    = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_req", {7'd0, int_req}, 8'h00);
      chk("rst_en",  int_en,  8'h00);
      chk("rst_vec", int_vec, 8'h00);
      chk("nohit_low", {7'd0, hit}, 8'h00);
      reset_n = 1'b1;
      tick();

      // Configuration and register window
      wr(8'd0, 8'h01);
      wr(8'd1, 8'h0F);
      wr(8'd3, 8'h80);
      chk("int_en", int_en, 8'h01);
      rd("mask_rd", 8'd1, 8'h0F);
      rd("vbase_rd", 8'd3, 8'h80);
      rd("eoi_rd", 8'd5, 8'h00);
      addr = 8'hF6;
      #1;
      chk("nohit_high", {7'd0, hit}, 8'h00);
      chk("nohit_data", r_data, 8'h00);
      wr(8'd1, 8'hFF);
      rd("mask_upper", 8'd1, 8'h0F);

      // Single source: irq[2]
      irq = 4'b0100;
      tick();
      rd("s_pend", 8'd2, 8'h04);
      chk("s_req_k", {7'd0, int_req}, 8'h00);
      tick();
      chk("s_req", {7'd0, int_req}, 8'h01);
      chk("s_vec", int_vec, 8'h88);
      rd("s_cause", 8'd4, 8'h02);
      rd("s_pend_clr", 8'd2, 8'h00);
      irq = 4'b0000;
      tick();
      chk("s_req_drop", {7'd0, int_req}, 8'h00);
      tick();
      chk("s_req_hold", {7'd0, int_req}, 8'h00);
      chk("s_vec_hold", int_vec, 8'h88);
      wr(8'd5, 8'h00);

      // Priority and hold-off: irq[3] and irq[1] together
      irq = 4'b1010;
      tick();
      rd("p_pend", 8'd2, 8'h0A);
      chk("p_req_k", {7'd0, int_req}, 8'h00);
      tick();
      chk("p_req", {7'd0, int_req}, 8'h01);
      chk("p_vec", int_vec, 8'h84);
      rd("p_cause", 8'd4, 8'h01);
      rd("p_pend_left", 8'd2, 8'h08);
      irq = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("p_holdoff", {7'd0, int_req}, 8'h00);
      end
      wr(8'd5, 8'h00);
      chk("p_eoi_edge", {7'd0, int_req}, 8'h00);
      tick();
      chk("p_req2", {7'd0, int_req}, 8'h01);
      chk("p_vec2", int_vec, 8'h8C);
      rd("p_cause2", 8'd4, 8'h03);
      rd("p_pend2", 8'd2, 8'h00);
      tick();
      chk("p_req2_drop", {7'd0, int_req}, 8'h00);
      wr(8'd5, 8'h00);

      // Masking
      wr(8'd1, 8'h01);
      irq = 4'b0010;
      tick();
      rd("m_pend", 8'd2, 8'h02);
      tick();
      chk("m_masked", {7'd0, int_req}, 8'h00);
      wr(8'd1, 8'h03);
      chk("m_same_edge", {7'd0, int_req}, 8'h00);
      tick();
      chk("m_req", {7'd0, int_req}, 8'h01);
      rd("m_cause", 8'd4, 8'h01);
      chk("m_vec", int_vec, 8'h84);
      irq = 4'b0000;
      tick();
      wr(8'd5, 8'h00);

      // Global enable
      wr(8'd0, 8'h00);
      chk("g_int_en", int_en, 8'h00);
      irq = 4'b0001;
      tick();
      rd("g_pend", 8'd2, 8'h01);
      tick();
      chk("g_blocked", {7'd0, int_req}, 8'h00);
      tick();
      chk("g_blocked2", {7'd0, int_req}, 8'h00);
      wr(8'd0, 8'h01);
      chk("g_same_edge", {7'd0, int_req}, 8'h00);
      tick();
      chk("g_req", {7'd0, int_req}, 8'h01);
      chk("g_vec", int_vec, 8'h80);
      rd("g_cause", 8'd4, 8'h00);
      irq = 4'b0000;
      tick();
      wr(8'd5, 8'h00);

      // W1C race
      wr(8'd0, 8'h00);
      irq    = 4'b0010;
      addr   = 8'hF2;
      w_data = 8'h02;
      w_en   = 1'b1;
      tick();
      w_en   = 1'b0;
      rd("w1c_race", 8'd2, 8'h02);
      wr(8'd2, 8'h02);
      rd("w1c_clear", 8'd2, 8'h00);
      irq = 4'b0000;

      // Vector wrap, EOI ignored in IDLE and REQ
      wr(8'd3, 8'hFC);
      wr(8'd0, 8'h01);
      wr(8'd5, 8'h00);
      chk("w_eoi_idle", {7'd0, int_req}, 8'h00);
      tick();
      chk("w_eoi_idle2", {7'd0, int_req}, 8'h00);
      irq = 4'b0010;
      tick();
      tick();
      chk("w_req", {7'd0, int_req}, 8'h01);
      chk("w_vec", int_vec, 8'h00);
      rd("w_cause", 8'd4, 8'h01);
      wr(8'd5, 8'h00);
      chk("w_eoi_req", {7'd0, int_req}, 8'h00);
      irq = 4'b0011;
      tick();
      rd("w_pend0", 8'd2, 8'h01);
      tick();
      chk("w_still_svc", {7'd0, int_req}, 8'h00);
      tick();
      chk("w_still_svc2", {7'd0, int_req}, 8'h00);
      wr(8'd5, 8'h00);
      tick();
      chk("w_req2", {7'd0, int_req}, 8'h01);
      chk("w_vec2", int_vec, 8'hFC);
      tick();
      chk("w_req2_drop", {7'd0, int_req}, 8'h00);

      // Reset in SERVICE with PEND=0101
      wr(8'd1, 8'h0F);
      irq = 4'b0000;
      tick();
      irq = 4'b0101;
      tick();
      rd("r_pend_pre", 8'd2, 8'h05);
      reset_n = 1'b0;
      #1;
      chk("r_req", {7'd0, int_req}, 8'h00);
      chk("r_en",  int_en,  8'h00);
      chk("r_vec", int_vec, 8'h00);
      rd("r_ctrl",  8'd0, 8'h00);
      rd("r_mask",  8'd1, 8'h00);
      rd("r_pend",  8'd2, 8'h00);
      rd("r_vbase", 8'd3, 8'h00);
      rd("r_cause", 8'd4, 8'h00);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      tick();
      chk("r_post_req", {7'd0, int_req}, 8'h00);
      rd("r_post_pend", 8'd2, 8'h05);
      tick();
      chk("r_post_req2", {7'd0, int_req}, 8'h00);
      tick();
      chk("r_post_req3", {7'd0, int_req}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
